// File: rtl/mssd_pkg.sv
// ----------------------------------------------------------------------------
// mssd_pkg
// Shared types and default widths for the serial data-transfer controller.
//   state_e      : controller FSM state encoding
//   DEF_PORT_W   : default destination-port field width
//   DEF_NUM_W    : default data-length field width
// Optional build macro: DATA_TRANS_PARITY_EN adds the PAR state.
// ----------------------------------------------------------------------------
package mssd_pkg;

  localparam int DEF_PORT_W = 2;
  localparam int DEF_NUM_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PORT = 3'd1,
    ST_NUM  = 3'd2,
    ST_LOAD = 3'd3,
    ST_DATA = 3'd4,
`ifdef DATA_TRANS_PARITY_EN
    ST_PAR  = 3'd5,
`endif
    ST_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/data_len_cnt.sv
// ----------------------------------------------------------------------------
// data_len_cnt
// Loadable payload down-counter that saturates at zero.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   load_i     : load load_val_i (has priority over en_i)
//   en_i       : decrement by one (ignored when already zero)
//   load_val_i : value to load
//   cnt_o      : current count
//   zero_o     : count equals zero
// ----------------------------------------------------------------------------
module data_len_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: next-state logic assigns its default first, so every path writes
  // cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only; reset is
  // synchronous, so it lives inside the clocked branch rather than the
  // sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_trans_ctrl.sv
// ----------------------------------------------------------------------------
// data_trans_ctrl
// Serial frame receiver: start bit (0), PORT_W port bits MSB-first, NUM_W
// length bits MSB-first, one internal LOAD slot, then N payload bits that are
// forwarded to serOut. Every bit slot is qualified by clkEn.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset (wins over clkEn)
//   clkEn    : bit-slot enable
//   serIn    : serial input, idle-high
//   port     : destination port, updated at LOAD, held until next LOAD
//   serOut   : forwarded payload bit (0 when serValid is 0)
//   serValid : serOut carries a payload bit this cycle
//   busy     : FSM not idle
//   done     : one-cycle end-of-frame pulse
//   parErr   : (DATA_TRANS_PARITY_EN only) even-parity mismatch, with done
// Optional build macro: DATA_TRANS_PARITY_EN adds a trailing even-parity bit.
// ----------------------------------------------------------------------------
module data_trans_ctrl
  import mssd_pkg::*;
#(
  parameter int NUM_W  = DEF_NUM_W,
  parameter int PORT_W = DEF_PORT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              serIn,
  output logic [PORT_W-1:0] port,
  output logic              serOut,
  output logic              serValid,
  output logic              busy,
`ifdef DATA_TRANS_PARITY_EN
  output logic              parErr,
`endif
  output logic              done
);

  localparam int MAX_W = (PORT_W > NUM_W) ? PORT_W : NUM_W;
  localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

`ifdef DATA_TRANS_PARITY_EN
  localparam state_e ST_AFTER_PAY = ST_PAR;
`else
  localparam state_e ST_AFTER_PAY = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PORT_W-1:0] port_sr_q, port_sr_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic [NUM_W-1:0]  len_sr_q, len_sr_d;
  logic              cnt_load, cnt_en, cnt_zero;
  logic [NUM_W-1:0]  cnt;
`ifdef DATA_TRANS_PARITY_EN
  logic              par_acc_q, par_acc_d;
  logic              par_err_q, par_err_d;
`endif

  data_len_cnt #(.W(NUM_W)) u_len_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (len_sr_q),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    port_sr_d = port_sr_q;
    len_sr_d  = len_sr_q;
    port_d    = port_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
`ifdef DATA_TRANS_PARITY_EN
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (clkEn && !serIn) begin
          state_d = ST_PORT;
          idx_d   = '0;
        end
      end
      ST_PORT: begin
        if (clkEn) begin
          port_sr_d = (port_sr_q << 1) | PORT_W'(serIn);
          if (idx_q == IDX_W'(PORT_W - 1)) begin
            idx_d   = '0;
            state_d = ST_NUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_NUM: begin
        if (clkEn) begin
          len_sr_d = (len_sr_q << 1) | NUM_W'(serIn);
          if (idx_q == IDX_W'(NUM_W - 1)) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_LOAD: begin
        // Slot spent on loading; serIn is not consumed here.
        if (clkEn) begin
          cnt_load = 1'b1;
          port_d   = port_sr_q;
`ifdef DATA_TRANS_PARITY_EN
          par_acc_d = 1'b0;
`endif
          state_d  = (len_sr_q != '0) ? ST_DATA : ST_AFTER_PAY;
        end
      end
      ST_DATA: begin
        if (clkEn) begin
          cnt_en = 1'b1;
`ifdef DATA_TRANS_PARITY_EN
          par_acc_d = par_acc_q ^ serIn;
`endif
          // The zero term is a defensive exit; a loaded counter is never 0 here.
          if ((cnt == NUM_W'(1)) || cnt_zero) begin
            state_d = ST_AFTER_PAY;
          end
        end
      end
`ifdef DATA_TRANS_PARITY_EN
      ST_PAR: begin
        if (clkEn) begin
          par_err_d = par_acc_q ^ serIn;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      port_sr_q <= '0;
      len_sr_q  <= '0;
      port_q    <= '0;
`ifdef DATA_TRANS_PARITY_EN
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      port_sr_q <= port_sr_d;
      len_sr_q  <= len_sr_d;
      port_q    <= port_d;
`ifdef DATA_TRANS_PARITY_EN
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  // serValid is also gated by rst so a reset cycle never forwards a bit.
  assign serValid = rst && clkEn && (state_q == ST_DATA);
  assign serOut   = serValid & serIn;
  assign port     = port_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
`ifdef DATA_TRANS_PARITY_EN
  assign parErr   = (state_q == ST_DONE) && par_err_q;
`endif

endmodule

// File: tb/tb_data_trans_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_trans_ctrl
// Builds each frame as a list of bit slots and checks, cycle by cycle, which
// slot the design should be consuming and what it should present.
// Honours DATA_TRANS_PARITY_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_data_trans_ctrl;

  localparam int PORT_W    = 2;
  localparam int NUM_W     = 4;
  localparam int LOAD_SLOT = 1 + PORT_W + NUM_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              clkEn;
  logic              serIn;
  logic [PORT_W-1:0] port;
  logic              serOut;
  logic              serValid;
  logic              busy;
  logic              done;
`ifdef DATA_TRANS_PARITY_EN
  logic              parErr;
`endif

  int errors = 0;
  int checks = 0;
  logic [PORT_W-1:0] exp_port = '0;

  always #5 clk = ~clk;

  data_trans_ctrl #(.NUM_W(NUM_W), .PORT_W(PORT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clkEn    (clkEn),
    .serIn    (serIn),
    .port     (port),
    .serOut   (serOut),
    .serValid (serValid),
    .busy     (busy),
`ifdef DATA_TRANS_PARITY_EN
    .parErr   (parErr),
`endif
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, sample at the falling edge, return #1 after
  // the next rising edge.
  task automatic drive_cycle(input logic en, input logic b,
                             output logic v, output logic o, output logic d,
                             output logic bz, output logic [PORT_W-1:0] p);
    clkEn = en;
    serIn = b;
    @(negedge clk);
    v  = serValid;
    o  = serOut;
    d  = done;
    bz = busy;
    p  = port;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    logic v, o, d, bz;
    logic [PORT_W-1:0] p;
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'b1, v, o, d, bz, p);
      check("idle_busy", bz, 1'b0);
      check("idle_valid", v, 1'b0);
    end
  endtask

  // mode: 0 = clkEn always 1, 1 = alternating 1/0, 2 = random.
  // abort_at >= 0 pulls rst low on that payload bit.
  task automatic run_frame(input logic [PORT_W-1:0] fp, input int n,
                           input logic [15:0] pay, input logic pbit,
                           input int mode, input int abort_at);
    logic slots[$];
    logic en, b, v, o, d, bz, exp_v;
    logic [PORT_W-1:0] p;
    int s, cyc, first_pay;
    logic par;
    slots.push_back(1'b0);
    for (int i = PORT_W - 1; i >= 0; i--) slots.push_back(fp[i]);
    for (int i = NUM_W - 1; i >= 0; i--) slots.push_back(n[i]);
    slots.push_back(1'($urandom_range(0, 1)));  // LOAD slot, content ignored
    first_pay = slots.size();
    par = 1'b0;
    for (int i = 0; i < n; i++) begin
      slots.push_back(pay[n-1-i]);
      par = par ^ pay[n-1-i];
    end
`ifdef DATA_TRANS_PARITY_EN
    slots.push_back(pbit);
`endif
    s   = 0;
    cyc = 0;
    while (s < slots.size() && cyc < 2000) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      b = en ? slots[s] : 1'($urandom_range(0, 1));
      if (abort_at >= 0 && en && s == first_pay + abort_at) begin
        rst = 1'b0;
        drive_cycle(en, b, v, o, d, bz, p);
        check("rst_cycle_valid", v, 1'b0);
        rst = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_port", port, '0);
        check("rst_valid", serValid, 1'b0);
        exp_port = '0;
        drive_cycle(1'b1, 1'b1, v, o, d, bz, p);
        check("post_rst_done", d, 1'b0);
        check("post_rst_busy", bz, 1'b0);
        return;
      end
      drive_cycle(en, b, v, o, d, bz, p);
      exp_v = en && (s >= first_pay) && (s < first_pay + n);
      check("serValid", v, exp_v);
      check("serOut", o, exp_v ? slots[s] : 1'b0);
      check("done_early", d, 1'b0);
      check("busy", bz, s >= 1);
      check("port_hold", p, (s > LOAD_SLOT) ? fp : exp_port);
      if (en) s++;
      cyc++;
    end
    if (cyc >= 2000) check("frame_timeout", 32'(s), 32'(slots.size()));
    // DONE cycle: serIn (even a 0) must not start a new frame.
    drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v, o, d, bz, p);
    check("done_pulse", d, 1'b1);
    check("done_busy", bz, 1'b1);
    check("done_valid", v, 1'b0);
    check("done_port", p, fp);
`ifdef DATA_TRANS_PARITY_EN
    check("parErr", parErr, par ^ pbit);
`else
    if (par && pbit) check("parity_unused", 32'(pbit), 32'(pbit & par));
`endif
    exp_port = fp;
    drive_cycle(1'($urandom_range(0, 1)), 1'b1, v, o, d, bz, p);
    check("after_done", d, 1'b0);
    check("after_busy", bz, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    clkEn = 1'b0;
    serIn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_valid", serValid, 1'b0);
    check("reset_serOut", serOut, 1'b0);
    check("reset_port", port, '0);
`ifdef DATA_TRANS_PARITY_EN
    check("reset_parErr", parErr, 1'b0);
`endif
    rst = 1'b1;
    idle_cycles(2);

    run_frame(2'd2, 3, 16'b101, 1'b1, 0, -1);   // payload 101, parity bit 1
    idle_cycles(1);
    run_frame(2'd2, 3, 16'b101, 1'b0, 0, -1);   // same payload, parity bit 0
    idle_cycles(1);
    run_frame(2'd3, 0, 16'h0, 1'b0, 0, -1);     // zero-length frame
    idle_cycles(1);
    run_frame(2'd1, 2, 16'b11, 1'b0, 1, -1);    // clkEn toggling
    idle_cycles(1);
    run_frame(2'd0, 15, 16'h5a3c, 1'b0, 0, -1); // maximum length
    idle_cycles(1);
    run_frame(2'd3, 5, 16'b10110, 1'b1, 0, 2);  // reset mid-payload
    run_frame(2'd2, 4, 16'b1001, 1'b0, 2, -1);  // normal frame after reset

    for (int k = 0; k < 40; k++) begin
      idle_cycles($urandom_range(0, 3));
      run_frame(PORT_W'($urandom_range(0, 3)), $urandom_range(0, 15),
                16'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
